// File: rtl/frame_scanout.sv
// frame_scanout: 160x120x3 framebuffer with plot write port, clear sweep and
// 640x480@60 VGA scan-out using 4x4 pixel replication.
module frame_scanout #(
   parameter logic [2:0] BG_COLOUR = 3'b000,
   parameter int         CH_WIDTH  = 10
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic [7:0]          x,
   input  logic [6:0]          y,
   input  logic [2:0]          colour,
   input  logic                plot,
   input  logic                clear,
   output logic                busy,
   output logic                frame_tick,
   output logic                VGA_CLK,
   output logic                VGA_HS,
   output logic                VGA_VS,
   output logic                VGA_BLANK_N,
   output logic                VGA_SYNC_N,
   output logic [CH_WIDTH-1:0] VGA_R,
   output logic [CH_WIDTH-1:0] VGA_G,
   output logic [CH_WIDTH-1:0] VGA_B
);
   localparam int NPIX = 19200;
   typedef enum logic {S_IDLE, S_FILL} state_t;
   state_t      r_state, w_state_nxt;
   logic [14:0] r_caddr, w_caddr_nxt;
   logic        r_pix_en, r_tick;
   logic [9:0]  r_hcnt, r_vcnt;
   logic [14:0] r_addr1;
   logic        r_hs1, r_vs1, r_vis1, r_hs2, r_vs2, r_vis2, r_hs3, r_vs3, r_vis3;
   logic [2:0]  r_rd, r_pix3;
   logic [2:0]  r_mem [NPIX];
   logic        w_vis, w_hend, w_plot_ok, w_we;
   logic [14:0] w_raddr, w_waddr;
   logic [2:0]  w_wdata;

   always_ff @(posedge clk or negedge resetn)
      if (!resetn) begin
         r_state <= S_IDLE;
         r_caddr <= 15'd0;
      end else begin
         r_state <= w_state_nxt;
         r_caddr <= w_caddr_nxt;
      end

   always_comb begin
      w_state_nxt = (r_state == S_IDLE) ? (clear ? S_FILL : S_IDLE)
                                        : ((r_caddr == 15'(NPIX - 1)) ? S_IDLE : S_FILL);
      w_caddr_nxt = (r_state == S_FILL) ? r_caddr + 15'd1 : 15'd0;
   end

   always_comb busy = (r_state == S_FILL);

   // the clear sweep owns the single write port while busy
   assign w_plot_ok = plot && !busy && (x < 8'd160) && (y < 7'd120);
   assign w_we      = busy || w_plot_ok;
   assign w_waddr   = busy ? r_caddr : 15'(y) * 15'd160 + 15'(x);
   assign w_wdata   = busy ? BG_COLOUR : colour;

   assign w_vis   = (r_hcnt < 10'd640) && (r_vcnt < 10'd480);
   assign w_hend  = (r_hcnt == 10'd799);
   assign w_raddr = w_vis ? 15'(r_vcnt[8:2]) * 15'd160 + 15'(r_hcnt[9:2]) : 15'd0;

   always_ff @(posedge clk) begin
      if (w_we)
         r_mem[w_waddr] <= w_wdata;
      if (r_pix_en)
         r_rd <= r_mem[r_addr1];
   end

   always_ff @(posedge clk or negedge resetn)
      if (!resetn) begin
         r_pix_en <= 1'b0;
         r_tick   <= 1'b0;
         r_hcnt   <= 10'd0;
         r_vcnt   <= 10'd0;
         r_addr1  <= 15'd0;
         {r_hs1, r_vs1, r_vis1} <= 3'b110;
         {r_hs2, r_vs2, r_vis2} <= 3'b110;
         {r_hs3, r_vs3, r_vis3} <= 3'b110;
         r_pix3   <= 3'b000;
      end else begin
         r_pix_en <= !r_pix_en;
         r_tick   <= r_pix_en && w_hend && (r_vcnt == 10'd479);
         if (r_pix_en) begin
            r_hcnt <= w_hend ? 10'd0 : r_hcnt + 10'd1;
            if (w_hend)
               r_vcnt <= (r_vcnt == 10'd524) ? 10'd0 : r_vcnt + 10'd1;
            r_addr1 <= w_raddr;
            r_hs1   <= !((r_hcnt >= 10'd656) && (r_hcnt <= 10'd751));
            r_vs1   <= !((r_vcnt >= 10'd490) && (r_vcnt <= 10'd491));
            r_vis1  <= w_vis;
            {r_hs2, r_vs2, r_vis2} <= {r_hs1, r_vs1, r_vis1};
            {r_hs3, r_vs3, r_vis3} <= {r_hs2, r_vs2, r_vis2};
            r_pix3  <= r_vis2 ? r_rd : 3'b000;
         end
      end

   assign frame_tick  = r_tick;
   assign VGA_CLK     = r_pix_en;
   assign VGA_HS      = r_hs3;
   assign VGA_VS      = r_vs3;
   assign VGA_BLANK_N = r_vis3;
   assign VGA_SYNC_N  = 1'b0;
   assign VGA_R       = {CH_WIDTH{r_pix3[2]}};
   assign VGA_G       = {CH_WIDTH{r_pix3[1]}};
   assign VGA_B       = {CH_WIDTH{r_pix3[0]}};
endmodule

// File: doc/frame_scanout.md
Name: frame_scanout

Overview:
- Consumer end of the pixel-plot interface driven by the game's display renderer.
- Accepts x/y/colour/plot writes into an internal 160x120x3 framebuffer.
- Continuously reads the framebuffer back out as 640x480@60 Hz VGA, replicating each stored pixel 4x4.
- Provides a frame tick for game pacing and a framebuffer clear sequencer.

Parameters:
- BG_COLOUR, 3'b000, colour written by the clear sequencer.
- CH_WIDTH, 10, width of each VGA_R/G/B output; stored colour bit is replicated across all bits.

Ports:
- clk  in  1  system clock, 50 MHz.
- resetn  in  1  asynchronous, active-low reset.
- x  in  8  write column, 0..159.
- y  in  7  write row, 0..119.
- colour  in  3  {R,G,B} write data.
- plot  in  1  write strobe, sampled every clk.
- clear  in  1  start a framebuffer fill with BG_COLOUR.
- busy  out  1  high while the clear sweep runs.
- frame_tick  out  1  one-clk pulse at start of vertical blanking.
- VGA_CLK  out  1  25 MHz pixel clock (clk/2).
- VGA_HS  out  1  horizontal sync, active low.
- VGA_VS  out  1  vertical sync, active low.
- VGA_BLANK_N  out  1  high during visible region.
- VGA_SYNC_N  out  1  tied 0.
- VGA_R, VGA_G, VGA_B  out  CH_WIDTH  colour channels.

Behaviour:
- Reset (async, resetn=0):
  - pix_en=0, hcnt=0, vcnt=0, clear FSM to IDLE.
  - Outputs: busy=0, frame_tick=0, VGA_HS=1, VGA_VS=1, VGA_BLANK_N=0, RGB=0, VGA_CLK=0.
  - Framebuffer contents are not altered by reset.
- Pixel enable:
  - pix_en toggles every clk; VGA_CLK = registered pix_en.
  - Counters and the scan pipeline advance only when pix_en=1.
- Horizontal counter hcnt (0..799, wraps to 0):
  - visible 0..639, front porch 640..655, sync 656..751, back porch 752..799.
- Vertical counter vcnt (0..524):
  - increments when hcnt wraps 799->0; wraps 524->0.
  - visible 0..479, front porch 480..489, sync 490..491, back porch 492..524.
- Read address = (vcnt>>2)*160 + (hcnt>>2), range 0..19199; computed only for visible positions.
- Scan pipeline, in pix_en ticks:
  - Stage 1 registers the address, raw hsync/vsync and visible flag.
  - Stage 2 performs a synchronous RAM read; syncs and visible flag are delayed alongside.
  - Stage 3 registers outputs.
  - Total latency from counter to pins is 3 pix_en ticks. HS, VS and BLANK_N carry identical latency, so the pixel/sync relationship is exact.
- Visible output: each channel = its stored bit replicated to CH_WIDTH.
- Non-visible output: all channels 0, BLANK_N=0.
- frame_tick: single clk pulse on the pix_en tick where vcnt goes 479->480 at hcnt=0.
- Write port:
  - When plot=1, busy=0, x<160 and y<120, mem[y*160+x] <= colour on that clk edge.
  - Out-of-range coordinates are ignored silently.
  - Writes are accepted every clk; no backpressure except busy.
- Read-during-write to the same address returns the old data; the new data is visible on the next read.
- Clear FSM:
  - IDLE: clear=1 -> FILL, addr=0, busy=1.
  - FILL: write BG_COLOUR at addr each clk; addr increments. At addr=19199 the write occurs, then -> IDLE and busy=0 on the next clk.
  - clear asserted during FILL is ignored; it does not restart the sweep.
  - plot is ignored while busy=1.
  - Scan-out continues during FILL and shows partially cleared content.
- Reset mid-FILL: sweep aborts, busy=0; memory is left partially cleared.

Test Plan:
- Timing: release reset, run 2 frames.
  - HS low width 96 pix_en ticks, period 800.
  - VS low for 2 lines, period 525 lines.
  - frame_tick period 840,000 clk.
  - BLANK_N high exactly 640x480 ticks per frame.
- Write/readback:
  - plot x=5, y=3, colour=3'b101.
  - In visible output rows 12..15 and columns 20..23, R and B are all-ones and G=0.
  - Neighbouring pixels keep their prior value.
- Out of range: plot x=160 y=0 and x=0 y=120, colour=3'b111 -> no framebuffer location changes; checked by full-frame comparison.
- Clear:
  - Fill memory with 3'b010, assert clear for 1 clk -> busy high for exactly 19200 clk.
  - Concurrent plots are ignored.
  - Next full frame is all BG_COLOUR.
  - A second clear pulse mid-sweep does not extend busy.
- Reset mid-operation: resetn=0 during FILL at addr~9000 and mid-line -> outputs immediately take reset values, busy=0; scan restarts at hcnt=0, vcnt=0 after release.
- Read-during-write: plot to the address currently being fetched -> that pixel shows the old colour, and the new colour on the next line repeat.
